gpio_bank: RTL
==============

Name: gpio_bank

Overview:
- Parametrised N-pin GPIO controller; generalises the single bidirectional GPIO pin currently wired at the FPGA top level.
- Per pin: output data, output enable, input synchroniser, glitch debounce filter, and rise/fall edge interrupts with W1C pending bits.
- Sits on the SoC peripheral bus. Pin-level tristate buffers stay in the FPGA/ASIC top, which also gates gpio_oe with reset.

Parameters:
- NPINS, 8, number of GPIO pins, 1..32.
- SYNC_STAGES, 2, input synchroniser flops, minimum 2.
- DB_W, 16, width of the debounce threshold register and of each per-pin debounce counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- reg_valid  in  1  bus request
- reg_ready  out  1  bus acknowledge, one-cycle pulse
- reg_we  in  1  1 = write, 0 = read
- reg_addr  in  5  byte address, bits [4:2] select the register
- reg_wdata  in  32  write data
- reg_rdata  out  32  read data, valid while reg_ready = 1
- gpio_in  in  NPINS  raw, asynchronous pad inputs
- gpio_out  out  NPINS  pad output data
- gpio_oe  out  NPINS  pad output enable, 1 = drive
- irq  out  1  level interrupt = OR of all pending bits

Behaviour:
- Reset: all registers clear.
  - gpio_out = 0, gpio_oe = 0, irq = 0, reg_ready = 0, reg_rdata = 0.
  - Synchroniser flops, debounced state and debounce counters clear to 0.
  - Reset mid-transaction aborts it; no ready is produced.
- Register map (byte offsets). Bits at NPINS and above read 0 and ignore writes.
  - 0x00 OUT: RW, drives gpio_out.
  - 0x04 OE: RW, drives gpio_oe.
  - 0x08 IN: RO, debounced input state.
  - 0x0C RISE_EN: RW.
  - 0x10 FALL_EN: RW.
  - 0x14 PENDING: write-1-to-clear; reads return pending bits.
  - 0x18 DB_THRESH: RW, DB_W bits, upper bits read 0.
  - 0x1C: reads 0, writes ignored.
- Handshake:
  - reg_ready pulses exactly one cycle, in the cycle after reg_valid is sampled high.
  - No new request is accepted while reg_ready = 1.
  - Master holds valid, we, addr and wdata stable until ready.
  - Write takes effect at the ready edge. gpio_out and gpio_oe change in the same cycle reg_ready is high.
  - reg_rdata is registered; it is 0 when reg_ready = 0.
- Input path:
  - SYNC_STAGES flop chain per pin produces s[i].
  - Debounce when DB_THRESH = 0: bypass; IN[i] = s[i] one cycle later.
  - Debounce when DB_THRESH = T > 0:
    - If s[i] == IN[i], cnt[i] clears to 0.
    - Otherwise cnt[i] increments.
    - When cnt[i] == T-1 while s[i] != IN[i], IN[i] <= s[i] and cnt[i] <= 0.
    - A mismatch must persist T consecutive cycles to propagate.
    - Counter saturates; no wrap.
- Latency with T = 0: pad change to IN visible is SYNC_STAGES+1 cycles. With T > 0: SYNC_STAGES+T cycles.
- Edge detect on IN:
  - rise[i] = IN[i] & ~IN_d[i]; fall[i] = ~IN[i] & IN_d[i].
  - PENDING[i] sets when (rise & RISE_EN) | (fall & FALL_EN).
  - Enables gate setting only. Clearing an enable does not clear pending.
- Simultaneous W1C and new event on the same bit in the same cycle: the set wins and the bit stays 1.
- irq is registered; it asserts one cycle after any pending bit sets.
- DB_THRESH writes take effect immediately. In-flight counters continue against the new threshold; a counter already at or above T-1 commits on the next mismatching cycle.

Test Plan:
- Reset state: assert rst mid-read -> reg_ready never pulses; gpio_oe = 0, gpio_out = 0, irq = 0; all registers read 0 after release.
- Write OUT = 0xA5, OE = 0x0F (NPINS = 8) -> gpio_out = 0xA5, gpio_oe = 0x0F in the ready cycle; readback returns the same values; write 0xFFFF_FFFF to OE -> reads 0xFF.
- DB_THRESH = 0: gpio_in[3] 0→1 -> IN bit 3 = 1 exactly 3 cycles later; RISE_EN = 0x08 -> PENDING = 0x08 and irq = 1 one cycle later.
- DB_THRESH = 4: 3-cycle glitch on gpio_in[0] -> IN unchanged, no pending; 4-cycle pulse -> IN[0] toggles after SYNC_STAGES+4 cycles, then toggles back after a further 4-cycle low.
- FALL_EN = 0x01: W1C PENDING = 0x01 in the same cycle as a falling edge on pin 0 -> PENDING[0] remains 1 and irq stays high; a second W1C clears it and irq deasserts.
- Back-to-back requests: valid held high across a ready pulse -> one transaction per two cycles; reg_rdata = 0 whenever reg_ready = 0.

Source files
------------

// File: rtl/gpio_bank.sv
// gpio_bank: N-pin GPIO controller with synchronised, debounced inputs and
// W1C rise/fall edge interrupts behind a one-cycle valid/ready register bus.
module gpio_bank #(
    parameter int unsigned NPINS       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DB_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             reg_valid,
    output logic             reg_ready,
    input  logic             reg_we,
    input  logic [4:0]       reg_addr,
    input  logic [31:0]      reg_wdata,
    output logic [31:0]      reg_rdata,
    input  logic [NPINS-1:0] gpio_in,
    output logic [NPINS-1:0] gpio_out,
    output logic [NPINS-1:0] gpio_oe,
    output logic             irq
);
    typedef enum logic [2:0] {
        A_OUT  = 3'd0,
        A_OE   = 3'd1,
        A_IN   = 3'd2,
        A_RISE = 3'd3,
        A_FALL = 3'd4,
        A_PEND = 3'd5,
        A_DB   = 3'd6,
        A_RSVD = 3'd7
    } reg_sel_e;

    localparam logic [DB_W-1:0] DB_ONE = DB_W'(1);

    logic [NPINS-1:0] sync_q [SYNC_STAGES];
    logic [DB_W-1:0]  cnt_q  [NPINS];
    logic [NPINS-1:0] in_q, in_d_q, rise_en_q, fall_en_q, pend_q;
    logic [DB_W-1:0]  thresh_q;
    logic [NPINS-1:0] s, set, clr;
    logic [31:0]      rd_val;
    logic             accept, wr;
    reg_sel_e         sel;
    logic             unused_bits;

    assign sel         = reg_sel_e'(reg_addr[4:2]);
    assign accept      = reg_valid & ~reg_ready;
    assign wr          = accept & reg_we;
    assign s           = sync_q[SYNC_STAGES-1];
    assign set         = (in_q & ~in_d_q & rise_en_q) | (~in_q & in_d_q & fall_en_q);
    assign clr         = (wr && sel == A_PEND) ? reg_wdata[NPINS-1:0] : '0;
    assign unused_bits = ^{reg_addr[1:0], reg_wdata};

    always_comb begin
        rd_val = '0;
        case (sel)
            A_OUT:   rd_val[NPINS-1:0] = gpio_out;
            A_OE:    rd_val[NPINS-1:0] = gpio_oe;
            A_IN:    rd_val[NPINS-1:0] = in_q;
            A_RISE:  rd_val[NPINS-1:0] = rise_en_q;
            A_FALL:  rd_val[NPINS-1:0] = fall_en_q;
            A_PEND:  rd_val[NPINS-1:0] = pend_q;
            A_DB:    rd_val[DB_W-1:0]  = thresh_q;
            default: rd_val = '0;
        endcase
    end

    // Register file, handshake and interrupt state; a same-cycle set beats W1C.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_ready <= 1'b0;
            reg_rdata <= '0;
            gpio_out  <= '0;
            gpio_oe   <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            thresh_q  <= '0;
            pend_q    <= '0;
            irq       <= 1'b0;
        end else begin
            reg_ready <= accept;
            reg_rdata <= (accept && !reg_we) ? rd_val : '0;
            if (wr) begin
                case (sel)
                    A_OUT:   gpio_out  <= reg_wdata[NPINS-1:0];
                    A_OE:    gpio_oe   <= reg_wdata[NPINS-1:0];
                    A_RISE:  rise_en_q <= reg_wdata[NPINS-1:0];
                    A_FALL:  fall_en_q <= reg_wdata[NPINS-1:0];
                    A_DB:    thresh_q  <= reg_wdata[DB_W-1:0];
                    default: ;
                endcase
            end
            pend_q <= (pend_q & ~clr) | set;
            irq    <= |pend_q;
        end
    end

    // Counter holds the number of prior mismatching cycles, so a mismatch
    // commits once it has persisted thresh_q cycles (>= tolerates shrinking T).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            for (int unsigned i = 0; i < NPINS; i++) cnt_q[i] <= '0;
            in_q   <= '0;
            in_d_q <= '0;
        end else begin
            sync_q[0] <= gpio_in;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            in_d_q <= in_q;
            for (int unsigned i = 0; i < NPINS; i++) begin
                if (s[i] == in_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (thresh_q == '0 || cnt_q[i] >= thresh_q - DB_ONE) begin
                    in_q[i]  <= s[i];
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] != '1) begin
                    cnt_q[i] <= cnt_q[i] + DB_ONE;
                end
            end
        end
    end
endmodule
